// File: rtl/regfile_wb.sv
// Write-back stage and 32x32 architectural register file with same-cycle
// write-to-read bypass, a debug read port and a committed-write counter.
module regfile_wb #(
    parameter int unsigned PC_BIT    = 32,
    parameter int unsigned DATAW_BIT = 2,
    parameter int unsigned REQW_BIT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [31:0]          alu_data_res,
    input  logic [31:0]          datamem_data,
    input  logic [PC_BIT-1:0]    pc_4,
    input  logic [4:0]           rd,
    input  logic [4:0]           rt,
    input  logic [DATAW_BIT-1:0] mux_regfile_data_w,
    input  logic [REQW_BIT-1:0]  mux_regfile_req_w,
    input  logic                 regfile_w_en,
    input  logic [4:0]           ra_addr,
    input  logic [4:0]           rb_addr,
    output logic [31:0]          ra_data,
    output logic [31:0]          rb_data,
    input  logic [4:0]           dbg_addr,
    output logic [31:0]          dbg_data,
    output logic                 wb_valid,
    output logic [4:0]           wb_addr,
    output logic [31:0]          wb_data,
    output logic [31:0]          wb_count
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam logic [ADDR_W-1:0] REG_ZERO = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] REG_LINK = ADDR_W'(31);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] wb_count_q;
    logic [DATA_W-1:0] wb_count_d;
    logic [DATA_W-1:0] pc_ext;

    assign pc_ext = DATA_W'(pc_4);

    // Write-back value select; encoding 3 aliases the ALU result
    always_comb begin
        wb_data = alu_data_res;
        case (mux_regfile_data_w)
            DATAW_BIT'(1): wb_data = datamem_data;
            DATAW_BIT'(2): wb_data = pc_ext;
            default:       wb_data = alu_data_res;
        endcase
    end

    // Destination select; encoding 3 aliases rd, 2 is the link register
    always_comb begin
        wb_addr = rd;
        case (mux_regfile_req_w)
            REQW_BIT'(1): wb_addr = rt;
            REQW_BIT'(2): wb_addr = REG_LINK;
            default:      wb_addr = rd;
        endcase
    end

    // A write only counts when enabled and not aimed at $0
    assign wb_valid = en & regfile_w_en & (wb_addr != REG_ZERO);

    // Next-state for storage and counter
    always_comb begin
        regs_d     = regs_q;
        wb_count_d = wb_count_q;
        if (wb_valid) begin
            regs_d[wb_addr] = wb_data;
            wb_count_d      = wb_count_q + DATA_W'(1);
        end
    end

    // State registers; reset wins over a simultaneous commit
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            wb_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wb_count_q <= wb_count_d;
        end
    end

    // Read ports: $0 hard-wired, then bypass of the current candidate, then storage
    assign ra_data  = (ra_addr == REG_ZERO) ? '0 :
                      (wb_valid && (ra_addr == wb_addr)) ? wb_data : regs_q[ra_addr];
    assign rb_data  = (rb_addr == REG_ZERO) ? '0 :
                      (wb_valid && (rb_addr == wb_addr)) ? wb_data : regs_q[rb_addr];
    assign dbg_data = (dbg_addr == REG_ZERO) ? '0 :
                      (wb_valid && (dbg_addr == wb_addr)) ? wb_data : regs_q[dbg_addr];

    assign wb_count = wb_count_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: table of input/expected records, expectations queued
// at drive time and popped when outputs are sampled after the falling edge.
module tb_regfile_wb;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] alu_data_res;
    logic [31:0] datamem_data;
    logic [31:0] pc_4;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic [1:0]  mux_regfile_data_w;
    logic [1:0]  mux_regfile_req_w;
    logic        regfile_w_en;
    logic [4:0]  ra_addr;
    logic [4:0]  rb_addr;
    logic [31:0] ra_data;
    logic [31:0] rb_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_count;

    int errors = 0;
    int checks = 0;

    regfile_wb #(.PC_BIT(32), .DATAW_BIT(2), .REQW_BIT(2)) dut (
        .clk(clk), .rst(rst), .en(en),
        .alu_data_res(alu_data_res), .datamem_data(datamem_data), .pc_4(pc_4),
        .rd(rd), .rt(rt),
        .mux_regfile_data_w(mux_regfile_data_w), .mux_regfile_req_w(mux_regfile_req_w),
        .regfile_w_en(regfile_w_en),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_count(wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        wen;
        logic [1:0]  dsel;
        logic [1:0]  rsel;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rt;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  dbg;
        logic        ev;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic [31:0] era;
        logic [31:0] erb;
        logic [31:0] edbg;
        logic [31:0] ecnt;
    } vec_t;

    typedef struct {
        int          id;
        logic        ev;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic [31:0] era;
        logic [31:0] erb;
        logic [31:0] edbg;
        logic [31:0] ecnt;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[11];

    task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", id, name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, queue its expectation, then check
    task automatic apply(input int id, input vec_t v);
        exp_t e;
        @(negedge clk);
        rst = v.rst; en = v.en; regfile_w_en = v.wen;
        mux_regfile_data_w = v.dsel; mux_regfile_req_w = v.rsel;
        alu_data_res = v.alu; datamem_data = v.mem; pc_4 = v.pc;
        rd = v.rd; rt = v.rt; ra_addr = v.ra; rb_addr = v.rb; dbg_addr = v.dbg;
        e = '{id, v.ev, v.ea, v.ed, v.era, v.erb, v.edbg, v.ecnt};
        sb.push_back(e);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL vec%0d scoreboard: got empty queue expected 1 entry", id);
        end else begin
            e = sb.pop_front();
            chk(e.id, "wb_valid", 32'(wb_valid), 32'(e.ev));
            chk(e.id, "wb_addr",  32'(wb_addr),  32'(e.ea));
            chk(e.id, "wb_data",  wb_data,  e.ed);
            chk(e.id, "ra_data",  ra_data,  e.era);
            chk(e.id, "rb_data",  rb_data,  e.erb);
            chk(e.id, "dbg_data", dbg_data, e.edbg);
            chk(e.id, "wb_count", wb_count, e.ecnt);
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; en = 1'b0; regfile_w_en = 1'b0;
        mux_regfile_data_w = 2'd0; mux_regfile_req_w = 2'd0;
        alu_data_res = '0; datamem_data = '0; pc_4 = '0;
        rd = '0; rt = '0; ra_addr = '0; rb_addr = '0; dbg_addr = '0;
        repeat (2) @(posedge clk);

        // After reset every address reads 0 on all ports and the counter is 0
        for (int a = 0; a < 32; a++) begin
            v = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0,
                  5'(a), 5'(31 - a), 5'(a),
                  1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
            apply(100 + a, v);
        end

        //          rst   en    wen   dsel  rsel  alu           mem           pc            rd     rt     ra     rb     dbg    ev    ea     ed            era           erb           edbg          ecnt
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 32'h12345678, 32'h0,        32'h0,        5'd5,  5'd0,  5'd5,  5'd5,  5'd0,  1'b1, 5'd5,  32'h12345678, 32'h12345678, 32'h12345678, 32'h0,        32'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h0,        32'h0,        32'h0,        5'd5,  5'd0,  5'd5,  5'd0,  5'd5,  1'b0, 5'd5,  32'h0,        32'h12345678, 32'h0,        32'h12345678, 32'd1};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 2'd2, 2'd2, 32'h11,       32'h0,        32'h00400008, 5'd3,  5'd4,  5'd31, 5'd3,  5'd31, 1'b1, 5'd31, 32'h00400008, 32'h00400008, 32'h0,        32'h00400008, 32'd1};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 2'd1, 2'd1, 32'h22,       32'hDEADBEEF, 32'h0,        5'd2,  5'd9,  5'd9,  5'd31, 5'd5,  1'b1, 5'd9,  32'hDEADBEEF, 32'hDEADBEEF, 32'h00400008, 32'h12345678, 32'd2};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 32'hFFFFFFFF, 32'h0,        32'h0,        5'd0,  5'd0,  5'd0,  5'd0,  5'd9,  1'b0, 5'd0,  32'hFFFFFFFF, 32'h0,        32'h0,        32'hDEADBEEF, 32'd3};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 32'h0000AAAA, 32'h0,        32'h0,        5'd7,  5'd0,  5'd7,  5'd7,  5'd7,  1'b0, 5'd7,  32'h0000AAAA, 32'h0,        32'h0,        32'h0,        32'd3};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 32'h0000AAAA, 32'h0,        32'h0,        5'd7,  5'd0,  5'd7,  5'd7,  5'd7,  1'b1, 5'd7,  32'h0000AAAA, 32'h0000AAAA, 32'h0000AAAA, 32'h0000AAAA, 32'd3};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h0,        32'h0,        32'h0,        5'd7,  5'd0,  5'd7,  5'd9,  5'd31, 1'b0, 5'd7,  32'h0,        32'h0000AAAA, 32'hDEADBEEF, 32'h00400008, 32'd4};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 2'd3, 2'd3, 32'hCAFEF00D, 32'h1,        32'h4,        5'd12, 5'd13, 5'd12, 5'd13, 5'd0,  1'b1, 5'd12, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        32'h0,        32'd4};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 32'h0BADF00D, 32'h0,        32'h0,        5'd12, 5'd0,  5'd12, 5'd12, 5'd12, 1'b1, 5'd12, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 32'd5};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h0,        32'h0,        32'h0,        5'd12, 5'd0,  5'd12, 5'd5,  5'd9,  1'b0, 5'd12, 32'h0,        32'h0BADF00D, 32'h12345678, 32'hDEADBEEF, 32'd6};

        for (int i = 0; i < 11; i++) begin
            apply(i, tbl[i]);
        end

        // Reset coincident with a valid write: bypass still visible that cycle
        v = '{1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 32'h55, 32'h0, 32'h0, 5'd3, 5'd0, 5'd3, 5'd12, 5'd31,
              1'b1, 5'd3, 32'h55, 32'h55, 32'h0BADF00D, 32'h00400008, 32'd6};
        apply(200, v);
        // Write discarded, everything cleared, counter back to 0
        v = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd0, 5'd3, 5'd12, 5'd31,
              1'b0, 5'd3, 32'h0, 32'h0, 32'h0, 32'h0, 32'd0};
        apply(201, v);
        // Fresh behaviour after reset: commit then read from storage
        v = '{1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 32'h77, 32'h0, 32'h0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0,
              1'b1, 5'd3, 32'h77, 32'h0, 32'h0, 32'h0, 32'd0};
        apply(202, v);
        v = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd0, 5'd3, 5'd3, 5'd3,
              1'b0, 5'd3, 32'h0, 32'h77, 32'h77, 32'h77, 32'd1};
        apply(203, v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
